// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared types, constants and line-align helper for the prefetch MSHR
package prefetch_pkg;

  localparam int unsigned DEF_ADDR_W     = 64;
  localparam int unsigned DEF_LINE_BYTES = 8;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_DISTANCE   = 8;
  localparam int unsigned DEF_TAG_W      = 4;
  localparam logic [63:0] DEF_RESET_PC   = 64'd0;

  // Entries are stored at maximum widths; users slice down to their parameters.
  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned MAX_TAG_W  = 8;

  localparam logic [MAX_TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic                  valid;
    logic                  stale;
    logic [MAX_TAG_W-1:0]  tag;
    logic [MAX_ADDR_W-1:0] addr;
  } mshr_entry_t;

  function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] a,
                                                       input int unsigned line_bytes);
    return a & ~(MAX_ADDR_W'(line_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/prefetch_mshr_table.sv
// rtl/prefetch_mshr_table.sv - MSHR entry array: lowest-free pick, tag match, stale marking
module prefetch_mshr_table
  import prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_i,
  input  logic              alloc_i,
  input  logic [TAG_W-1:0]  alloc_tag_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic [TAG_W-1:0]  fill_tag_i,
  output logic              free_avail_o,
  output logic              fill_hit_o,
  output logic              fill_stale_o,
  output logic [ADDR_W-1:0] fill_addr_o,
  output logic              busy_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mshr_entry_t          entry_q [DEPTH];
  mshr_entry_t          entry_d [DEPTH];
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 hit;
  logic [IDX_W-1:0]     hit_idx;
  logic                 any_valid;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!entry_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    hit       = 1'b0;
    hit_idx   = '0;
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | entry_q[i].valid;
      if (MAX_TAG_W'(fill_tag_i) != TAG_NONE && entry_q[i].valid &&
          entry_q[i].tag == MAX_TAG_W'(fill_tag_i)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign free_avail_o = free_found;
  assign fill_hit_o   = hit;
  assign fill_stale_o = entry_q[hit_idx].stale;
  assign fill_addr_o  = entry_q[hit_idx].addr[ADDR_W-1:0];
  assign busy_o       = any_valid;

  // Fill-free happens before allocation so a just-freed slot is never reused in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (hit && hit_idx == IDX_W'(i)) entry_d[i].valid = 1'b0;
      if (redirect_i && entry_d[i].valid) entry_d[i].stale = 1'b1;
    end
    if (alloc_i && free_found) begin
      entry_d[free_idx].valid = 1'b1;
      entry_d[free_idx].stale = redirect_i;
      entry_d[free_idx].tag   = MAX_TAG_W'(alloc_tag_i);
      entry_d[free_idx].addr  = MAX_ADDR_W'(alloc_addr_i);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      if (alloc_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          assert (!(entry_q[i].valid && !(hit && hit_idx == IDX_W'(i)) &&
                    entry_q[i].tag == MAX_TAG_W'(alloc_tag_i)))
            else $error("duplicate MSHR tag allocated");
        end
      end
    end
  end

endmodule

// File: rtl/prefetch_mshr.sv
// rtl/prefetch_mshr.sv - instruction prefetcher with MSHR tracking; PREFETCH_STATS_EN adds counters
module prefetch_mshr
  import prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       LINE_BYTES = DEF_LINE_BYTES,
  parameter int unsigned       DEPTH      = DEF_DEPTH,
  parameter int unsigned       DISTANCE   = DEF_DISTANCE,
  parameter int unsigned       TAG_W      = DEF_TAG_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              load_request,
  input  logic              store_request,
  input  logic              mem_grant,
  input  logic [TAG_W-1:0]  mem_response,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [63:0]       mem_data,
  output logic              pf_request,
  output logic [ADDR_W-1:0] pf_addr,
  output logic              pf_fill_valid,
  output logic [ADDR_W-1:0] pf_fill_addr,
  output logic [63:0]       pf_fill_data,
  output logic              pf_busy
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_filled,
  output logic [31:0]       stat_squashed
`endif
);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] LEAD_MAX  = ADDR_W'(DISTANCE * LINE_BYTES);
  localparam logic [ADDR_W-1:0] PTR_RESET =
    ADDR_W'(line_align(MAX_ADDR_W'(RESET_PC), LINE_BYTES)) + LINE_STEP;

  logic [ADDR_W-1:0] pf_ptr_q, pf_ptr_d;
  logic [ADDR_W-1:0] align_fetch, align_next, lead;
  logic              redirect, accept, free_avail;
  logic              fill_hit, fill_stale;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_valid_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [63:0]       fill_data_q;

  assign align_fetch = ADDR_W'(line_align(MAX_ADDR_W'(fetch_pc), LINE_BYTES));
  assign align_next  = ADDR_W'(line_align(MAX_ADDR_W'(next_pc), LINE_BYTES));
  assign redirect    = (next_pc != fetch_pc) && (next_pc != fetch_pc + LINE_STEP);
  assign lead        = pf_ptr_q - align_fetch;

  assign pf_request = !reset && !redirect && !load_request && !store_request &&
                      free_avail && (lead < LEAD_MAX);
  assign pf_addr    = pf_ptr_q;
  assign accept     = pf_request && mem_grant && (mem_response != '0);

  always_comb begin
    pf_ptr_d = pf_ptr_q;
    if (redirect)    pf_ptr_d = align_next + LINE_STEP;
    else if (accept) pf_ptr_d = pf_ptr_q + LINE_STEP;
  end

  prefetch_mshr_table #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) u_table (
    .clock        (clock),
    .reset        (reset),
    .redirect_i   (redirect),
    .alloc_i      (accept),
    .alloc_tag_i  (mem_response),
    .alloc_addr_i (pf_ptr_q),
    .fill_tag_i   (mem_tag),
    .free_avail_o (free_avail),
    .fill_hit_o   (fill_hit),
    .fill_stale_o (fill_stale),
    .fill_addr_o  (fill_addr),
    .busy_o       (pf_busy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pf_ptr_q     <= PTR_RESET;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      pf_ptr_q     <= pf_ptr_d;
      fill_valid_q <= fill_hit && !fill_stale;
      if (fill_hit && !fill_stale) begin
        fill_addr_q <= fill_addr;
        fill_data_q <= mem_data;
      end
    end
  end

  assign pf_fill_valid = fill_valid_q;
  assign pf_fill_addr  = fill_addr_q;
  assign pf_fill_data  = fill_data_q;

`ifdef PREFETCH_STATS_EN
  logic [31:0] issued_q, filled_q, squashed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      issued_q   <= '0;
      filled_q   <= '0;
      squashed_q <= '0;
    end else begin
      if (accept && issued_q != '1) issued_q <= issued_q + 32'd1;
      if (fill_hit && !fill_stale && filled_q != '1) filled_q <= filled_q + 32'd1;
      if (fill_hit && fill_stale && squashed_q != '1) squashed_q <= squashed_q + 32'd1;
    end
  end

  assign stat_issued   = issued_q;
  assign stat_filled   = filled_q;
  assign stat_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_prefetch_mshr.sv
// tb/tb_prefetch_mshr.sv - directed scoreboard bench for prefetch_mshr
module tb_prefetch_mshr;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] fetch_pc, next_pc;
  logic        load_request, store_request, mem_grant;
  logic [3:0]  mem_response, mem_tag;
  logic [63:0] mem_data;
  logic        pf_request, pf_fill_valid, pf_busy;
  logic [63:0] pf_addr, pf_fill_addr, pf_fill_data;
`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_issued, stat_filled, stat_squashed;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } fill_t;
  fill_t exp_q[$];

  always #5 clock = ~clock;

  prefetch_mshr dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_pc      (fetch_pc),
    .next_pc       (next_pc),
    .load_request  (load_request),
    .store_request (store_request),
    .mem_grant     (mem_grant),
    .mem_response  (mem_response),
    .mem_tag       (mem_tag),
    .mem_data      (mem_data),
    .pf_request    (pf_request),
    .pf_addr       (pf_addr),
    .pf_fill_valid (pf_fill_valid),
    .pf_fill_addr  (pf_fill_addr),
    .pf_fill_data  (pf_fill_data),
    .pf_busy       (pf_busy)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_filled   (stat_filled),
    .stat_squashed (stat_squashed)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_fill(input logic [63:0] addr, input logic [63:0] data);
    fill_t f;
    f.addr = addr;
    f.data = data;
    exp_q.push_back(f);
  endtask

  // Every fill pulse must correspond to the oldest outstanding expected fill.
  always @(negedge clock) begin
    if (!reset && pf_fill_valid) begin
      fill_t f;
      if (exp_q.size() == 0) begin
        chk("unexpected_fill", pf_fill_addr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        f = exp_q.pop_front();
        chk("fill_addr", pf_fill_addr, f.addr);
        chk("fill_data", pf_fill_data, f.data);
      end
    end
  end

  initial begin
    reset = 1'b1; fetch_pc = '0; next_pc = '0;
    load_request = 1'b0; store_request = 1'b0;
    mem_grant = 1'b0; mem_response = '0; mem_tag = '0; mem_data = '0;
    tick(); tick();
    chk("req_in_reset", pf_request, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_fill_valid", pf_fill_valid, 1'b0);
    chk("rst_fill_addr", pf_fill_addr, 64'd0);
    chk("rst_fill_data", pf_fill_data, 64'd0);
    chk("rst_busy", pf_busy, 1'b0);
    chk("rst_req", pf_request, 1'b1);
    chk("rst_addr", pf_addr, 64'd8);
    tick();

    // fill all four entries
    mem_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      mem_response = 4'(i);
      #1;
      chk("issue_req", pf_request, 1'b1);
      chk("issue_addr", pf_addr, 64'(8 * i));
      tick();
    end
    mem_response = 4'd5;
    #1;
    chk("full_req", pf_request, 1'b0);
    chk("full_addr", pf_addr, 64'd40);
    chk("full_busy", pf_busy, 1'b1);

    // fill tag 3 while full and granted: no allocation, slot reused next cycle
    mem_tag = 4'd3; mem_data = 64'hDEADBEEF;
    push_fill(64'h18, 64'hDEADBEEF);
    #1;
    chk("fill_full_req", pf_request, 1'b0);
    tick();
    mem_tag = '0;
    #1;
    chk("realloc_req", pf_request, 1'b1);
    chk("realloc_addr", pf_addr, 64'd40);
    tick();
    mem_response = '0;
    #1;
    chk("refull_req", pf_request, 1'b0);

    // grant with response 0: retry same address
    mem_tag = 4'd1; mem_data = 64'h1111;
    push_fill(64'd8, 64'h1111);
    tick();
    mem_tag = '0;
    #1;
    chk("rej_req", pf_request, 1'b1);
    chk("rej_addr", pf_addr, 64'd48);
    tick();
    chk("retry_req", pf_request, 1'b1);
    chk("retry_addr", pf_addr, 64'd48);
    mem_response = 4'd6;
    tick();
    mem_response = 4'd7;

    // load yields the bus
    mem_tag = 4'd2; mem_data = 64'h2222;
    push_fill(64'd16, 64'h2222);
    tick();
    mem_tag = '0;
    load_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("load_req", pf_request, 1'b0);
      chk("load_addr", pf_addr, 64'd56);
      tick();
    end
    load_request = 1'b0;
    #1;
    chk("resume_req", pf_request, 1'b1);
    chk("resume_addr", pf_addr, 64'd56);
    tick();

    // distance limit: pf_ptr=64 leads fetch 0 by exactly DISTANCE lines
    mem_response = '0; mem_grant = 1'b0;
    mem_tag = 4'd4; mem_data = 64'h4444;
    push_fill(64'd32, 64'h4444);
    tick();
    mem_tag = '0;
    #1;
    chk("dist_block_req", pf_request, 1'b0);
    chk("dist_block_busy", pf_busy, 1'b1);
    fetch_pc = 64'd8; next_pc = 64'd8;
    #1;
    chk("dist_open_req", pf_request, 1'b1);
    chk("dist_open_addr", pf_addr, 64'd64);
    tick();

    // redirect squashes tags 5,6,7
    next_pc = 64'h400;
    mem_grant = 1'b1; mem_response = 4'd8;
    #1;
    chk("redir_req", pf_request, 1'b0);
    tick();
    fetch_pc = 64'h400;
    #1;
    chk("post_redir_req", pf_request, 1'b1);
    chk("post_redir_addr", pf_addr, 64'h408);
    mem_tag = 4'd5; mem_data = 64'h5555;
    tick();
    mem_grant = 1'b0; mem_response = '0;
    mem_tag = 4'd6; mem_data = 64'h6666;
    tick();
    mem_tag = 4'd8; mem_data = 64'h8888;
    push_fill(64'h408, 64'h8888);
    tick();
    mem_tag = 4'd9;
    tick();
    mem_tag = '0;
    tick();
    chk("stale_busy", pf_busy, 1'b1);
    mem_tag = 4'd7; mem_data = 64'h7777;
    tick();
    mem_tag = '0;
    tick();
    chk("drained_busy", pf_busy, 1'b0);
`ifdef PREFETCH_STATS_EN
    chk("stat_issued", stat_issued, 32'd8);
    chk("stat_filled", stat_filled, 32'd5);
    chk("stat_squashed", stat_squashed, 32'd3);
`endif

    // reset mid-flight discards outstanding tag 9
    mem_grant = 1'b1; mem_response = 4'd9;
    #1;
    chk("pre_rst_addr", pf_addr, 64'h410);
    tick();
    mem_grant = 1'b0; mem_response = '0;
    chk("pre_rst_busy", pf_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_tag = 4'd9; mem_data = 64'h9999;
    #1;
    chk("mid_rst_busy", pf_busy, 1'b0);
    chk("mid_rst_ptr", pf_addr, 64'd8);
    tick();
    mem_tag = '0;
    tick(); tick();
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
